// File: rtl/instruction_fetch_stage_pkg.sv
// Shared fetch-stage types: state encoding, word type, IF/ID payload and constants.
package cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    word_t instr;
    word_t pcplus4;
  } ifid_t;

  localparam word_t PC_INCR              = 32'd4;
  localparam word_t BUBBLE_INSTR_DEFAULT = 32'h0000_0000;
  localparam word_t RESET_PC_DEFAULT     = 32'h0000_0000;

  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and memory (slave).
interface instruction_fetch_stage_if;
  import cpu_pkg::*;

  logic  IMemReq;
  word_t IMemAddr;
  logic  IMemAck;
  word_t IMemData;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemAck,
    input  IMemData
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemAck,
    output IMemData
  );

endinterface

// File: rtl/instruction_fetch_stage_skid.sv
// One-entry holding register for a fetched word that arrived while decode was stalled.
module if_skid_buffer
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  logic  clear_i,
  input  ifid_t data_i,
  output ifid_t data_o,
  output logic  full_o
);

  ifid_t data_q, data_d;
  logic  full_q, full_d;

  // Clear wins over load so a redirect drops a word captured in the same cycle.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// PC register and IF/ID pipeline register fetching over a variable-latency req/ack bus.
module instruction_fetch_stage
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC     = RESET_PC_DEFAULT,
  parameter word_t BUBBLE_INSTR = BUBBLE_INSTR_DEFAULT
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Stall,
  input  logic                              Redirect,
  input  word_t                             RedirectPC,
  instruction_fetch_stage_if.master         imem,
  output word_t                             Instruction,
  output logic [15:0]                       Immediate,
  output word_t                             PCPlus4,
  output logic                              Valid
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pend_q, pend_d;
  ifid_t        ifid_q, ifid_d;
  logic         valid_q, valid_d;

  logic  ifid_load;
  logic  skid_load, skid_clear, skid_full;
  ifid_t skid_data;
  word_t pc_next;

  assign pc_next   = pc_q + PC_INCR;
  assign ifid_load = !(valid_q && Stall);

  if_skid_buffer u_skid (
    .clk     (Clk),
    .rst     (Rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  ('{instr: imem.IMemData, pcplus4: pc_next}),
    .data_o  (skid_data),
    .full_o  (skid_full)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    ifid_d     = ifid_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    imem.IMemReq  = (state_q != HOLD);
    imem.IMemAddr = (state_q == DISCARD) ? pend_q : pc_q;

    if (Redirect) begin
      pc_d         = word_align(RedirectPC);
      valid_d      = 1'b0;
      ifid_d.instr = BUBBLE_INSTR;
      skid_clear   = 1'b1;
      case (state_q)
        FETCH: begin
          // Outstanding request must still complete at its original address.
          if (!imem.IMemAck) begin
            pend_d  = pc_q;
            state_d = DISCARD;
          end
        end
        HOLD:    state_d = FETCH;
        DISCARD: if (imem.IMemAck) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.IMemAck) begin
            pc_d = pc_next;
            if (ifid_load) begin
              ifid_d  = '{instr: imem.IMemData, pcplus4: pc_next};
              valid_d = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end else if (ifid_load) begin
            valid_d      = 1'b0;
            ifid_d.instr = BUBBLE_INSTR;
          end
        end
        HOLD: begin
          if (!Stall) begin
            if (skid_full) begin
              ifid_d  = skid_data;
              valid_d = 1'b1;
            end
            skid_clear = 1'b1;
            state_d    = FETCH;
          end
        end
        DISCARD: begin
          if (ifid_load) begin
            valid_d      = 1'b0;
            ifid_d.instr = BUBBLE_INSTR;
          end
          if (imem.IMemAck) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      ifid_q  <= '{instr: BUBBLE_INSTR, pcplus4: '0};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ifid_q  <= ifid_d;
      valid_q <= valid_d;
    end
  end

  assign Instruction = ifid_q.instr;
  assign Immediate   = ifid_q.instr[15:0];
  assign PCPlus4     = ifid_q.pcplus4;
  assign Valid       = valid_q;

  ack_requires_req: assert property (@(posedge Clk) disable iff (Rst)
    imem.IMemAck |-> imem.IMemReq);

  addr_stable_until_ack: assert property (@(posedge Clk) disable iff (Rst)
    (imem.IMemReq && !imem.IMemAck) |=> (imem.IMemReq && $stable(imem.IMemAddr)));

  hold_has_word: assert property (@(posedge Clk) disable iff (Rst)
    (state_q == HOLD) |-> skid_full);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a scoreboard of fetched words.
module tb_instruction_fetch_stage;

  logic        Clk;
  logic        Rst, Stall, Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] Instruction, PCPlus4;
  logic [15:0] Immediate;
  logic        Valid;

  logic        Rst2, Stall2, Redirect2;
  logic [31:0] RedirectPC2;
  logic [31:0] Instruction2, PCPlus4_2;
  logic [15:0] Immediate2;
  logic        Valid2;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned lat;
  int unsigned wcnt;
  bit          disc;
  logic [63:0] sb_q[$];
  logic [63:0] sb_exp;

  instruction_fetch_stage_if bus1 ();
  instruction_fetch_stage_if bus2 ();

  instruction_fetch_stage u_dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .imem        (bus1.master),
    .Instruction (Instruction),
    .Immediate   (Immediate),
    .PCPlus4     (PCPlus4),
    .Valid       (Valid)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .Clk         (Clk),
    .Rst         (Rst2),
    .Stall       (Stall2),
    .Redirect    (Redirect2),
    .RedirectPC  (RedirectPC2),
    .imem        (bus2.master),
    .Instruction (Instruction2),
    .Immediate   (Immediate2),
    .PCPlus4     (PCPlus4_2),
    .Valid       (Valid2)
  );

  // Memory 1: acks after 'lat' waiting cycles; memory 2: zero-wait.
  assign bus1.IMemAck  = bus1.IMemReq && !Rst && (wcnt >= lat);
  assign bus1.IMemData = bus1.IMemAddr ^ 32'hA5A5_0000;
  assign bus2.IMemAck  = bus2.IMemReq && !Rst2;
  assign bus2.IMemData = bus2.IMemAddr ^ 32'hA5A5_0000;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Producer side: every accepted response not flushed by a redirect is expected in order.
  always @(posedge Clk) begin
    if (Rst) begin
      wcnt <= 0;
      sb_q.delete();
      disc = 1'b0;
    end else begin
      if (Redirect) sb_q.delete();
      if (bus1.IMemReq && bus1.IMemAck) begin
        if (!Redirect && !disc) sb_q.push_back({bus1.IMemData, bus1.IMemAddr + 32'd4});
        disc = 1'b0;
        wcnt <= 0;
      end else begin
        if (Redirect && bus1.IMemReq) disc = 1'b1;
        if (bus1.IMemReq) wcnt <= wcnt + 1;
      end
    end
  end

  // Consumer side: decode takes IF/ID on the coming edge when Valid && !Stall.
  always @(negedge Clk) begin
    if (!Rst && Valid && !Stall) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected observed=%h_%h expected=none", Instruction, PCPlus4);
      end
      if (sb_q.size() != 0) begin
        sb_exp = sb_q.pop_front();
        n_cmp++;
        assert ({Instruction, PCPlus4} === sb_exp) else begin
          n_err++;
          $error("FAIL sb_word observed=%h_%h expected=%h_%h",
                 Instruction, PCPlus4, sb_exp[63:32], sb_exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] a;

  initial begin
    Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0; lat = 0;
    Rst2 = 1'b1; Stall2 = 1'b0; Redirect2 = 1'b0; RedirectPC2 = '0;

    // Reset state and zero-wait streaming
    tick();
    tick();
    check("rst_valid", {31'd0, Valid}, 32'd0);
    check("rst_instr", Instruction, 32'd0);
    check("rst_pcp4", PCPlus4, 32'd0);
    Rst = 1'b0;
    #1;
    check("c1_req", {31'd0, bus1.IMemReq}, 32'd1);
    check("c1_addr", bus1.IMemAddr, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("zw_addr", bus1.IMemAddr, 32'(4 * i));
      check("zw_valid", {31'd0, Valid}, 32'd1);
      check("zw_pcp4", PCPlus4, 32'(4 * i));
      check("zw_instr", Instruction, 32'(4 * (i - 1)) ^ 32'hA5A5_0000);
      check("zw_imm", {16'd0, Immediate}, 32'(4 * (i - 1)));
    end

    // Ack three cycles late
    lat = 3;
    a = bus1.IMemAddr;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_valid", {31'd0, Valid}, 32'd0);
      check("wait_instr", Instruction, 32'd0);
      check("wait_addr", bus1.IMemAddr, a);
    end
    tick();
    check("late_valid", {31'd0, Valid}, 32'd1);
    check("late_instr", Instruction, a ^ 32'hA5A5_0000);
    check("late_pcp4", PCPlus4, a + 32'd4);

    // Stall for four cycles while the next ack arrives
    lat = 1;
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", {31'd0, Valid}, 32'd1);
      check("stall_instr", Instruction, a ^ 32'hA5A5_0000);
      if (i >= 1) check("hold_req", {31'd0, bus1.IMemReq}, 32'd0);
    end
    Stall = 1'b0;
    tick();
    check("skid_instr", Instruction, (a + 32'd4) ^ 32'hA5A5_0000);
    check("skid_pcp4", PCPlus4, a + 32'd8);
    check("skid_valid", {31'd0, Valid}, 32'd1);
    check("skid_next_addr", bus1.IMemAddr, a + 32'd8);

    // Redirect while address 8 is outstanding
    Rst = 1'b1; lat = 0;
    tick();
    Rst = 1'b0;
    tick();
    tick();
    check("pre_rd_addr", bus1.IMemAddr, 32'd8);
    lat = 3;
    tick();
    check("pre_rd_valid", {31'd0, Valid}, 32'd0);
    Redirect = 1'b1; RedirectPC = 32'h0000_0103;
    tick();
    Redirect = 1'b0;
    check("disc_addr0", bus1.IMemAddr, 32'd8);
    check("disc_req", {31'd0, bus1.IMemReq}, 32'd1);
    tick();
    check("disc_addr1", bus1.IMemAddr, 32'd8);
    tick();
    check("rd_addr", bus1.IMemAddr, 32'h0000_0100);
    check("rd_valid", {31'd0, Valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_wait_valid", {31'd0, Valid}, 32'd0);
      check("rd_wait_addr", bus1.IMemAddr, 32'h0000_0100);
    end
    tick();
    check("rd_valid1", {31'd0, Valid}, 32'd1);
    check("rd_instr", Instruction, 32'hA5A5_0100);
    check("rd_pcp4", PCPlus4, 32'h0000_0104);

    // Redirect + Stall + ack in the same cycle
    lat = 0;
    Stall = 1'b1; Redirect = 1'b1; RedirectPC = 32'h2000_0007;
    tick();
    Stall = 1'b0; Redirect = 1'b0;
    check("rsa_valid", {31'd0, Valid}, 32'd0);
    check("rsa_instr", Instruction, 32'd0);
    check("rsa_addr", bus1.IMemAddr, 32'h2000_0004);
    tick();
    check("rsa_next_instr", Instruction, 32'h85A5_0004);
    check("rsa_next_pcp4", PCPlus4, 32'h2000_0008);

    // PC wrap and reset during HOLD on the second instance
    Rst2 = 1'b0;
    #1;
    check("w_addr0", bus2.IMemAddr, 32'hFFFF_FFF8);
    tick();
    check("w_addr1", bus2.IMemAddr, 32'hFFFF_FFFC);
    check("w_pcp4_0", PCPlus4_2, 32'hFFFF_FFFC);
    check("w_instr0", Instruction2, 32'h5A5A_FFF8);
    tick();
    check("w_addr2", bus2.IMemAddr, 32'h0000_0000);
    check("w_pcp4_1", PCPlus4_2, 32'h0000_0000);
    check("w_instr1", Instruction2, 32'h5A5A_FFFC);
    Stall2 = 1'b1;
    tick();
    check("w_hold_req", {31'd0, bus2.IMemReq}, 32'd0);
    check("w_hold_instr", Instruction2, 32'h5A5A_FFFC);
    Rst2 = 1'b1;
    tick();
    check("w_rst_valid", {31'd0, Valid2}, 32'd0);
    check("w_rst_addr", bus2.IMemAddr, 32'hFFFF_FFF8);
    check("w_rst_req", {31'd0, bus2.IMemReq}, 32'd1);
    check("w_rst_instr", Instruction2, 32'd0);

    Rst = 1'b1;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
